// File: rtl/any1_pkg.sv
// Shared types and defaults for the any1 address-generation blocks.
package any1_pkg;

  localparam int ANY1_MAXVL = 64;

  typedef enum logic [1:0] {
    MODE_SCALAR  = 2'd0,
    MODE_SCALED  = 2'd1,
    MODE_STRIDED = 2'd2,
    MODE_INDEXED = 2'd3
  } agen_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } agen_state_t;

endpackage

// File: rtl/any1_vagen.sv
// Vector address generator: emits one effective address per enabled element
// for scalar, scaled-index, strided and gather/scatter addressing.
module any1_vagen
  import any1_pkg::*;
#(
  parameter int AWID  = 32,
  parameter int MAXVL = ANY1_MAXVL,
  parameter int LW    = $clog2(MAXVL) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [AWID-1:0] base,
  input  logic [AWID-1:0] disp,
  input  logic [AWID-1:0] stride,
  input  logic [1:0]      scale,
  input  logic [LW-1:0]   vl,
  input  logic [MAXVL-1:0] mask,
  output logic [LW-2:0]   idx_elem,
  input  logic [AWID-1:0] idx_i,
  output logic [AWID-1:0] ea_o,
  output logic [LW-2:0]   elem_o,
  output logic            ea_valid,
  input  logic            ea_ready,
  input  logic            abort,
  output logic            busy,
  output logic            done
);

  agen_state_t      state_q, state_d;
  agen_mode_t       mode_q, mode_d;
  logic [AWID-1:0]  bd_q, bd_d;
  logic [AWID-1:0]  stride_q, stride_d;
  logic [1:0]       scale_q, scale_d;
  logic [LW-1:0]    vl_q, vl_d;
  logic [MAXVL-1:0] mask_q, mask_d;
  logic [LW-1:0]    ptr_q, ptr_d;
  logic [AWID-1:0]  acc_q, acc_d;
  logic [AWID-1:0]  ea_q, ea_d;
  logic [LW-2:0]    elem_q, elem_d;
  logic             ea_valid_q, ea_valid_d;
  logic             done_q, done_d;

  agen_mode_t       cur_mode;
  logic [AWID-1:0]  cur_bd, cur_stride, cur_acc, cur_addr;
  logic [1:0]       cur_scale;
  logic [LW-1:0]    eff_vl;
  logic             idle, have_elem, elem_en, can_adv, step;

  // Element 0 is produced in the start cycle, so IDLE reads the live inputs
  // while RUN reads the latched copy.
  always_comb begin
    idle       = (state_q == ST_IDLE);
    cur_mode   = idle ? agen_mode_t'(mode) : mode_q;
    cur_bd     = idle ? (base + disp) : bd_q;
    cur_stride = idle ? stride : stride_q;
    cur_scale  = idle ? scale : scale_q;
    cur_acc    = idle ? (base + disp) : acc_q;
    eff_vl     = idle ? vl : vl_q;
    elem_en    = idle ? mask[ptr_q[LW-2:0]] : mask_q[ptr_q[LW-2:0]];
    if (cur_mode == MODE_SCALAR || cur_mode == MODE_SCALED) begin
      eff_vl  = LW'(1);
      elem_en = 1'b1;
    end
    case (cur_mode)
      MODE_SCALAR:  cur_addr = cur_bd;
      MODE_SCALED:  cur_addr = cur_bd + (cur_stride << cur_scale);
      MODE_STRIDED: cur_addr = cur_acc;
      default:      cur_addr = cur_bd + (idx_i << cur_scale);
    endcase
    have_elem = (ptr_q < eff_vl);
    can_adv   = !ea_valid_q || ea_ready;
  end

  // Next-state logic: sequencing, element stepping and output beat staging.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bd_d       = bd_q;
    stride_d   = stride_q;
    scale_d    = scale_q;
    vl_d       = vl_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    ea_d       = ea_q;
    elem_d     = elem_q;
    ea_valid_d = ea_valid_q;
    done_d     = 1'b0;
    step       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          mode_d     = agen_mode_t'(mode);
          bd_d       = base + disp;
          stride_d   = stride;
          scale_d    = scale;
          vl_d       = vl;
          mask_d     = mask;
          ea_valid_d = 1'b0;
          step       = have_elem;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d    = ST_DONE;
          ea_valid_d = 1'b0;
          done_d     = 1'b0 | 1'b1;
        end else if (can_adv) begin
          if (have_elem) begin
            step = 1'b1;
          end else begin
            state_d    = ST_DONE;
            ea_valid_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase

    // A masked-off element still advances the pointer and the accumulator.
    if (step) begin
      ptr_d      = ptr_q + LW'(1);
      acc_d      = cur_acc + cur_stride;
      ea_valid_d = elem_en;
      if (elem_en) begin
        ea_d   = cur_addr;
        elem_d = ptr_q[LW-2:0];
      end
    end
  end

  // State registers; configuration and accumulator are data and carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      ea_q       <= '0;
      elem_q     <= '0;
      ea_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ea_q       <= ea_d;
      elem_q     <= elem_d;
      ea_valid_q <= ea_valid_d;
      done_q     <= done_d;
    end
    mode_q   <= mode_d;
    bd_q     <= bd_d;
    stride_q <= stride_d;
    scale_q  <= scale_d;
    vl_q     <= vl_d;
    mask_q   <= mask_d;
    acc_q    <= acc_d;
  end

  assign idx_elem = ptr_q[LW-2:0];
  assign ea_o     = ea_q;
  assign elem_o   = elem_q;
  assign ea_valid = ea_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_any1_vagen.sv
// Directed bench for any1_vagen: each task runs one scenario and checks
// the recorded beats and done pulses against hand-computed values.
module tb_any1_vagen;

  localparam int AWID  = 32;
  localparam int MAXVL = 64;
  localparam int LW    = 7;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [1:0]       mode, scale;
  logic [AWID-1:0]  base, disp, stride, idx_i, ea_o;
  logic [LW-1:0]    vl;
  logic [MAXVL-1:0] mask;
  logic [LW-2:0]    idx_elem, elem_o;
  logic             ea_valid, ea_ready, busy, done;

  int n_chk = 0;
  int n_fail = 0;

  any1_vagen #(.AWID(AWID), .MAXVL(MAXVL), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base),
    .disp(disp), .stride(stride), .scale(scale), .vl(vl), .mask(mask),
    .idx_elem(idx_elem), .idx_i(idx_i), .ea_o(ea_o), .elem_o(elem_o),
    .ea_valid(ea_valid), .ea_ready(ea_ready), .abort(abort), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model for gather/scatter indices.
  logic [AWID-1:0] idx_tbl [0:MAXVL-1];
  assign idx_i = idx_tbl[idx_elem];

  // Back-pressure: optionally hold ready low for 3 cycles on element 1.
  logic ready_base;
  bit   stall_en;
  int   stall_cnt;
  assign ea_ready = ready_base && !(stall_en && ea_valid && elem_o == 6'd1 && stall_cnt < 3);
  always @(posedge clk) if (stall_en && ea_valid && !ea_ready) stall_cnt <= stall_cnt + 1;

  // Beat and done recorder.
  logic [AWID-1:0] b_ea[$];
  int              b_elem[$];
  int              b_cyc[$];
  logic [AWID-1:0] stall_ea[$];
  int done_cnt, done_cyc, start_cyc;
  always @(negedge clk) begin
    if (ea_valid && ea_ready) begin
      b_ea.push_back(ea_o);
      b_elem.push_back(int'(elem_o));
      b_cyc.push_back(cyc);
    end
    if (ea_valid && !ea_ready) stall_ea.push_back(ea_o);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic start_seq(input logic [1:0] m, input logic [31:0] b, input logic [31:0] d,
                           input logic [31:0] s, input logic [1:0] sc, input logic [6:0] v,
                           input logic [63:0] mk, input bit ab);
    @(posedge clk); #1;
    b_ea.delete(); b_elem.delete(); b_cyc.delete(); stall_ea.delete();
    done_cnt = 0; done_cyc = -1;
    mode = m; base = b; disp = d; stride = s; scale = sc; vl = v; mask = mk;
    start = 1'b1; abort = ab; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    mode = ~m; base = 32'h5555_0000; disp = 32'h0000_0777; stride = 32'h40;
    scale = ~sc; vl = 7'd17; mask = ~mk;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin @(posedge clk); #1; k++; end
    n_chk++;
    if (busy) begin n_fail++; $display("FAIL idle_timeout: busy=%0b required 0", busy); end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ea_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", ea_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_chk++; if ({ea_o, elem_o, idx_elem} !== '0) begin n_fail++; $display("FAIL reset_ea: ea=%h elem=%0d idx=%0d required 0", ea_o, elem_o, idx_elem); end
    rst = 1'b0;
  endtask

  task automatic test_scalar();
    start_seq(2'd0, 32'h1000, 32'h10, 32'h0, 2'd0, 7'd0, 64'h0, 1'b0);
    wait_idle();
    n_chk++; if (b_ea.size() != 1) begin n_fail++; $display("FAIL scalar_count: got %0d required 1", b_ea.size()); end
    else begin
      n_chk++; if (b_ea[0] !== 32'h1010 || b_elem[0] != 0) begin n_fail++; $display("FAIL scalar_ea: got %h/%0d required 1010/0", b_ea[0], b_elem[0]); end
      n_chk++; if (b_cyc[0] != start_cyc + 1) begin n_fail++; $display("FAIL scalar_latency: got %0d required %0d", b_cyc[0], start_cyc + 1); end
      n_chk++; if (done_cyc != b_cyc[0] + 1 || done_cnt != 1) begin n_fail++; $display("FAIL scalar_done: cyc %0d cnt %0d required %0d/1", done_cyc, done_cnt, b_cyc[0] + 1); end
    end
  endtask

  task automatic test_start_abort_idle();
    start_seq(2'd0, 32'h7000, 32'h4, 32'h0, 2'd0, 7'd0, 64'h0, 1'b1);
    wait_idle();
    n_chk++; if (b_ea.size() != 1 || done_cnt != 1) begin n_fail++; $display("FAIL idle_abort_count: beats %0d done %0d required 1/1", b_ea.size(), done_cnt); end
    else begin
      n_chk++; if (b_ea[0] !== 32'h7004) begin n_fail++; $display("FAIL idle_abort_ea: got %h required 7004", b_ea[0]); end
    end
  endtask

  task automatic test_scaled();
    start_seq(2'd1, 32'h400, 32'h20, 32'h3, 2'd3, 7'd0, 64'h0, 1'b0);
    wait_idle();
    n_chk++; if (b_ea.size() != 1) begin n_fail++; $display("FAIL scaled_count: got %0d required 1", b_ea.size()); end
    else begin
      n_chk++; if (b_ea[0] !== 32'h438 || b_elem[0] != 0) begin n_fail++; $display("FAIL scaled_ea: got %h/%0d required 438/0", b_ea[0], b_elem[0]); end
    end
  endtask

  task automatic test_back_to_back();
    start_seq(2'd2, 32'h2000, 32'h0, 32'h8, 2'd0, 7'd4, {64{1'b1}}, 1'b0);
    @(posedge clk); #1;
    mode = 2'd0; base = 32'hDEAD_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    n_chk++; if (b_ea.size() != 4) begin n_fail++; $display("FAIL strided_count: got %0d required 4", b_ea.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (b_ea[i] !== 32'h2000 + 32'(8 * i) || b_elem[i] != i || b_cyc[i] != start_cyc + 1 + i) begin
          n_fail++;
          $display("FAIL strided_beat%0d: got %h/%0d@%0d required %h/%0d@%0d", i, b_ea[i], b_elem[i], b_cyc[i],
                   32'h2000 + 32'(8 * i), i, start_cyc + 1 + i);
        end
      end
    end
    n_chk++; if (done_cnt != 1 || done_cyc != start_cyc + 5) begin n_fail++; $display("FAIL strided_done: cnt %0d cyc %0d required 1/%0d", done_cnt, done_cyc, start_cyc + 5); end
  endtask

  task automatic test_masked();
    start_seq(2'd2, 32'h2000, 32'h0, 32'h8, 2'd0, 7'd4, 64'hA, 1'b0);
    wait_idle();
    n_chk++; if (b_ea.size() != 2) begin n_fail++; $display("FAIL masked_count: got %0d required 2", b_ea.size()); end
    else begin
      n_chk++; if (b_ea[0] !== 32'h2008 || b_elem[0] != 1) begin n_fail++; $display("FAIL masked_beat0: got %h/%0d required 2008/1", b_ea[0], b_elem[0]); end
      n_chk++; if (b_ea[1] !== 32'h2018 || b_elem[1] != 3) begin n_fail++; $display("FAIL masked_beat1: got %h/%0d required 2018/3", b_ea[1], b_elem[1]); end
    end
  endtask

  task automatic test_indexed_stall();
    logic [AWID-1:0] exp_ea [3];
    exp_ea[0] = 32'h114; exp_ea[1] = 32'h100; exp_ea[2] = 32'h10C;
    idx_tbl[0] = 32'd5; idx_tbl[1] = 32'd0; idx_tbl[2] = 32'd3;
    stall_cnt = 0; stall_en = 1'b1;
    start_seq(2'd3, 32'h100, 32'h0, 32'h0, 2'd2, 7'd3, {64{1'b1}}, 1'b0);
    wait_idle();
    stall_en = 1'b0;
    n_chk++; if (b_ea.size() != 3) begin n_fail++; $display("FAIL gather_count: got %0d required 3", b_ea.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (b_ea[i] !== exp_ea[i] || b_elem[i] != i) begin n_fail++; $display("FAIL gather_beat%0d: got %h/%0d required %h/%0d", i, b_ea[i], b_elem[i], exp_ea[i], i); end
      end
      n_chk++; if (b_cyc[1] != start_cyc + 5 || b_cyc[2] != start_cyc + 6) begin n_fail++; $display("FAIL gather_stall_timing: got %0d,%0d required %0d,%0d", b_cyc[1], b_cyc[2], start_cyc + 5, start_cyc + 6); end
    end
    n_chk++; if (stall_ea.size() != 3) begin n_fail++; $display("FAIL stall_len: got %0d required 3", stall_ea.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (stall_ea[i] !== 32'h100) begin n_fail++; $display("FAIL stall_hold%0d: got %h required 100", i, stall_ea[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    start_seq(2'd2, 32'hFFFF_FFF8, 32'h0, 32'h8, 2'd0, 7'd2, {64{1'b1}}, 1'b0);
    wait_idle();
    n_chk++; if (b_ea.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d required 2", b_ea.size()); end
    else begin
      n_chk++; if (b_ea[0] !== 32'hFFFF_FFF8 || b_ea[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_ea: got %h,%h required fffffff8,00000000", b_ea[0], b_ea[1]); end
    end
  endtask

  task automatic test_abort();
    start_seq(2'd2, 32'h3000, 32'h0, 32'h4, 2'd0, 7'd8, {64{1'b1}}, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_chk++; if (ea_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_drop: got %b required 0", ea_valid); end
    wait_idle();
    n_chk++; if (b_ea.size() != 1 || done_cnt != 1) begin n_fail++; $display("FAIL abort_count: beats %0d done %0d required 1/1", b_ea.size(), done_cnt); end
    else begin
      n_chk++; if (b_ea[0] !== 32'h3000) begin n_fail++; $display("FAIL abort_ea: got %h required 3000", b_ea[0]); end
    end
  endtask

  task automatic test_vl_zero();
    start_seq(2'd3, 32'h100, 32'h0, 32'h0, 2'd0, 7'd0, {64{1'b1}}, 1'b0);
    wait_idle();
    n_chk++; if (b_ea.size() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL vl0_count: beats %0d done %0d required 0/1", b_ea.size(), done_cnt); end
    n_chk++; if (done_cyc - start_cyc > 2 || done_cyc < 0) begin n_fail++; $display("FAIL vl0_latency: got %0d required <=2", done_cyc - start_cyc); end
  endtask

  task automatic test_reset_mid();
    start_seq(2'd2, 32'h5000, 32'h0, 32'h10, 2'd0, 7'd8, {64{1'b1}}, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++; if (busy !== 1'b0 || ea_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: busy %b valid %b required 0/0", busy, ea_valid); end
    repeat (12) begin @(posedge clk); #1; end
    n_chk++; if (b_ea.size() != 1 || done_cnt != 0) begin n_fail++; $display("FAIL rst_mid_beats: beats %0d done %0d required 1/0", b_ea.size(), done_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; scale = 2'd0;
    base = '0; disp = '0; stride = '0; vl = '0; mask = '0;
    ready_base = 1'b1; stall_en = 1'b0; stall_cnt = 0;
    done_cnt = 0; done_cyc = -1; start_cyc = 0;
    for (int i = 0; i < MAXVL; i++) idx_tbl[i] = '0;
    test_reset();
    test_scalar();
    test_start_abort_idle();
    test_scaled();
    test_back_to_back();
    test_masked();
    test_indexed_stall();
    test_wrap();
    test_abort();
    test_vl_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
